// File: rtl/rps_round_ctrl_if.sv
// Player-facing bus of the rock-paper-scissors round controller.
// Latency: none (wires only); backpressure: none, the gesture valids are levels.
// Ports: start, p1/p2 valid+sig (master drives), capture_req, led, scores,
//        round_done, match_over, winner (slave drives).
interface rps_round_ctrl_if #(
  parameter int SCORE_W = 3
) ();
  logic               start;
  logic               p1_valid;
  logic [2:0]         p1_sig;
  logic               p2_valid;
  logic [2:0]         p2_sig;
  logic               capture_req;
  logic [2:0]         led;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               round_done;
  logic               match_over;
  logic [1:0]         winner;

  modport master (
    output start, p1_valid, p1_sig, p2_valid, p2_sig,
    input  capture_req, led, p1_score, p2_score, round_done, match_over, winner
  );

  modport slave (
    input  start, p1_valid, p1_sig, p2_valid, p2_sig,
    output capture_req, led, p1_score, p2_score, round_done, match_over, winner
  );
endinterface

// File: rtl/rps_round_ctrl.sv
// Sequences a rock-paper-scissors match: countdown, capture, judge, show, score.
// Latency: all outputs registered; JUDGE is one cycle after the last gesture latches.
// Backpressure: none; gestures are sampled only while capture_req is high, first sample wins.
// Ports: clk, reset (sync, active-high); bus (slave): start, p1/p2_valid, p1/p2_sig[2:0]
//        ([2] rock, [1] paper, [0] scissors) in; capture_req, led[2:0], p1/p2_score,
//        round_done, match_over, winner[1:0] (01 p1, 10 p2) out.
module rps_round_ctrl #(
  parameter int BEAT_CYCLES   = 12000000,
  parameter int TIMEOUT_BEATS = 4,
  parameter int SHOW_BEATS    = 2,
  parameter int WIN_SCORE     = 3,
  parameter int SCORE_W       = 3
) (
  input logic             clk,
  input logic             reset,
  rps_round_ctrl_if.slave bus
);

  localparam int CW   = $clog2(BEAT_CYCLES + 1);
  localparam int MAXB = (TIMEOUT_BEATS > SHOW_BEATS) ?
                        ((TIMEOUT_BEATS > 3) ? TIMEOUT_BEATS : 3) :
                        ((SHOW_BEATS > 3) ? SHOW_BEATS : 3);
  localparam int BW   = $clog2(MAXB + 1);

  localparam logic [CW-1:0]      BEAT_LAST  = CW'(BEAT_CYCLES - 1);
  localparam logic [BW-1:0]      COUNT_LAST = BW'(2);
  localparam logic [BW-1:0]      TO_LAST    = BW'(TIMEOUT_BEATS - 1);
  localparam logic [BW-1:0]      SHOW_LAST  = BW'(SHOW_BEATS - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_CAPTURE, S_JUDGE, S_SHOW, S_OVER
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_beat_cnt;
  logic [BW-1:0]      r_beat_num;
  logic               r_p1_lat, r_p2_lat;
  logic [2:0]         r_p1_sig, r_p2_sig;
  logic [2:0]         r_led;
  logic               r_capture_req, r_round_done, r_match_over;
  logic [1:0]         r_winner;
  logic [SCORE_W-1:0] r_p1_score, r_p2_score;

  logic       w_tick;
  logic       w_p1_ok, w_p2_ok, w_p1_beats, w_p2_beats;
  logic       w_p1_have, w_p2_have;
  logic [1:0] w_res;

  function automatic logic f_onehot3(input logic [2:0] s);
    return (s == 3'b100) || (s == 3'b010) || (s == 3'b001);
  endfunction

  // Round result to LED pattern: p1 on the left, p2 on the right, tie in the middle.
  function automatic logic [2:0] f_led(input logic [1:0] res);
    case (res)
      2'b01:   return 3'b100;
      2'b10:   return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  assign w_tick = (r_beat_cnt == BEAT_LAST);

  // A foul (non one-hot) is handled exactly like a missing player.
  assign w_p1_ok = r_p1_lat && f_onehot3(r_p1_sig);
  assign w_p2_ok = r_p2_lat && f_onehot3(r_p2_sig);

  // Valid only when both signatures are one-hot.
  assign w_p1_beats = (r_p1_sig[2] & r_p2_sig[0]) | (r_p1_sig[0] & r_p2_sig[1]) |
                      (r_p1_sig[1] & r_p2_sig[2]);
  assign w_p2_beats = (r_p2_sig[2] & r_p1_sig[0]) | (r_p2_sig[0] & r_p1_sig[1]) |
                      (r_p2_sig[1] & r_p1_sig[2]);

  always_comb begin
    w_res = 2'b00;
    if (w_p1_ok && w_p2_ok) begin
      if (w_p1_beats)      w_res = 2'b01;
      else if (w_p2_beats) w_res = 2'b10;
    end else if (w_p1_ok) begin
      w_res = 2'b01;
    end else if (w_p2_ok) begin
      w_res = 2'b10;
    end
  end

  // A gesture arriving this cycle counts, so the exit also sees same-cycle latches.
  assign w_p1_have = r_p1_lat | bus.p1_valid;
  assign w_p2_have = r_p2_lat | bus.p2_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= '0;
      r_beat_num    <= '0;
      r_p1_lat      <= 1'b0;
      r_p2_lat      <= 1'b0;
      r_p1_sig      <= 3'b000;
      r_p2_sig      <= 3'b000;
      r_led         <= 3'b000;
      r_capture_req <= 1'b0;
      r_round_done  <= 1'b0;
      r_match_over  <= 1'b0;
      r_winner      <= 2'b00;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
    end else begin
      r_round_done <= 1'b0;
      // Free-running beat timer; every state change below overrides it back to zero.
      if (w_tick) begin
        r_beat_cnt <= '0;
        r_beat_num <= r_beat_num + 1'b1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_COUNT;
            r_led      <= 3'b111;
            r_beat_cnt <= '0;
            r_beat_num <= '0;
          end
        end
        S_COUNT: begin
          if (w_tick) begin
            if (r_beat_num == COUNT_LAST) begin
              r_state       <= S_CAPTURE;
              r_led         <= 3'b000;
              r_capture_req <= 1'b1;
              r_beat_cnt    <= '0;
              r_beat_num    <= '0;
            end else begin
              r_led <= {1'b0, r_led[2:1]};  // 111 -> 011 -> 001
            end
          end
        end
        S_CAPTURE: begin
          if (bus.p1_valid && !r_p1_lat) begin
            r_p1_lat <= 1'b1;
            r_p1_sig <= bus.p1_sig;
          end
          if (bus.p2_valid && !r_p2_lat) begin
            r_p2_lat <= 1'b1;
            r_p2_sig <= bus.p2_sig;
          end
          if ((w_p1_have && w_p2_have) || (w_tick && r_beat_num == TO_LAST)) begin
            r_state       <= S_JUDGE;
            r_capture_req <= 1'b0;
            r_round_done  <= 1'b1;  // high for the single JUDGE cycle
            r_beat_cnt    <= '0;
            r_beat_num    <= '0;
          end
        end
        S_JUDGE: begin
          r_led <= f_led(w_res);
          if (w_res == 2'b01)      r_p1_score <= r_p1_score + 1'b1;
          else if (w_res == 2'b10) r_p2_score <= r_p2_score + 1'b1;
          r_p1_lat   <= 1'b0;
          r_p2_lat   <= 1'b0;
          r_state    <= S_SHOW;
          r_beat_cnt <= '0;
          r_beat_num <= '0;
        end
        S_SHOW: begin
          if (w_tick && r_beat_num == SHOW_LAST) begin
            // The deciding round was won by the match winner, so led already holds its pattern.
            if (r_p1_score == WIN || r_p2_score == WIN) begin
              r_state      <= S_OVER;
              r_match_over <= 1'b1;
              r_winner     <= (r_p1_score == WIN) ? 2'b01 : 2'b10;
            end else begin
              r_state <= S_COUNT;
              r_led   <= 3'b111;
            end
            r_beat_cnt <= '0;
            r_beat_num <= '0;
          end
        end
        S_OVER: begin
          if (bus.start) begin
            r_state      <= S_COUNT;
            r_led        <= 3'b111;
            r_p1_score   <= '0;
            r_p2_score   <= '0;
            r_winner     <= 2'b00;
            r_match_over <= 1'b0;
            r_beat_cnt   <= '0;
            r_beat_num   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.capture_req = r_capture_req;
  assign bus.led         = r_led;
  assign bus.p1_score    = r_p1_score;
  assign bus.p2_score    = r_p2_score;
  assign bus.round_done  = r_round_done;
  assign bus.match_over  = r_match_over;
  assign bus.winner      = r_winner;

endmodule

// File: doc/rps_round_ctrl.md
Name: rps_round_ctrl

Overview:
- Sequences one rock-paper-scissors match between two players on the FPGA.
- Each round runs as follows: countdown on the LEDs, capture both players' decoded gestures, judge the result, show it, update the scores.
- The match ends when a player reaches WIN_SCORE.
- Sits between the SPI-decoded gesture registers (one-hot rock/paper/scissors per player) and the 3-LED display and score outputs.

Parameters:
- BEAT_CYCLES, 12000000: clk cycles per beat (countdown step and timeout/show unit).
- TIMEOUT_BEATS, 4: beats allowed in CAPTURE before a missing player forfeits.
- SHOW_BEATS, 2: beats the result is held on the LEDs.
- WIN_SCORE, 3: round wins needed to end the match.
- SCORE_W, 3: score counter width; must hold WIN_SCORE.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start pulse, already debounced.
- p1_valid  in  1  player 1 gesture available (level).
- p1_sig  in  3  player 1 gesture: [2] rock, [1] paper, [0] scissors.
- p2_valid  in  1  player 2 gesture available (level).
- p2_sig  in  3  player 2 gesture, same encoding as p1_sig.
- capture_req  out  1  high while gestures are being accepted.
- led  out  3  countdown/result display.
- p1_score  out  SCORE_W  player 1 round wins.
- p2_score  out  SCORE_W  player 2 round wins.
- round_done  out  1  one-cycle pulse per judged round.
- match_over  out  1  high when a player has reached WIN_SCORE.
- winner  out  2  01 = p1 won the match, 10 = p2 won the match, 00 = none.

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state IDLE; led 000; scores 0; winner 00; capture_req, round_done and match_over all 0; latches cleared; beat counter 0.
- Reset asserted mid-round aborts immediately to these values.
- Beat counter: counts 0..BEAT_CYCLES-1; the beat tick occurs at the terminal count.
- The beat counter and the beat-in-state count clear on every state transition.
- States: IDLE, COUNT, CAPTURE, JUDGE, SHOW, OVER.
- IDLE: led 000. start moves to COUNT on the next cycle.
- COUNT: lasts exactly 3*BEAT_CYCLES cycles.
  - led shows 111, then 011, then 001, one value per beat.
  - Then moves to CAPTURE.
- CAPTURE:
  - capture_req = 1; led 000.
  - On a cycle with pX_valid = 1 and the player not yet latched, latch pX_sig and set the player's latched flag.
  - Later valids from that player are ignored (first sample wins).
  - Moves to JUDGE the cycle after both players are latched.
  - After TIMEOUT_BEATS*BEAT_CYCLES cycles, moves to JUDGE with any missing player marked absent.
  - If the last player latches in the same cycle as the timeout, the latch counts.
- Foul: a latched value that is not one-hot (000, or two or more bits set) is treated as a foul, same as absent.
- JUDGE (exactly 1 cycle):
  - Both players valid: rock beats scissors, scissors beats paper, paper beats rock; equal gestures tie.
  - One player valid: that player wins.
  - Neither valid: tie.
  - The winner's score increments by 1 (no saturation needed; the match ends at WIN_SCORE).
  - round_done pulses in this cycle; scores show the new value from the next cycle.
  - The latched flags clear.
- SHOW: lasts SHOW_BEATS*BEAT_CYCLES cycles.
  - led = 100 for a p1 win, 001 for a p2 win, 010 for a tie.
  - Then: if either score equals WIN_SCORE, move to OVER; otherwise move to COUNT.
- OVER:
  - match_over = 1; winner set; led holds the final winner pattern (100 or 001).
  - start clears the scores, winner and match_over, and moves to COUNT.
- start outside IDLE and OVER is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- BEAT_CYCLES=4, TIMEOUT_BEATS=4, SHOW_BEATS=2, WIN_SCORE=3.
- Reset then start: led 111/011/001 for 4 cycles each, then capture_req = 1 exactly 12 cycles after COUNT entry.
- In CAPTURE, p1 = 100 (rock), p2 = 001 (scissors), both valid the same cycle → JUDGE next cycle; round_done pulse; p1_score = 1; led = 100 for 8 cycles; then COUNT.
- p1 = 010 (paper) twice, with p2 = 010 (paper) → tie; scores unchanged; led = 010. Sending p1 = 100 after the first latch does not change the result.
- Only p2 sends 010 and p1 never responds → timeout after 16 cycles; p2_score increments. Repeat with p1_sig = 110 (foul) → p2 still wins.
- p1 wins 3 rounds → match_over = 1, winner = 01, led = 100 held; start clears the scores to 0 and led shows 111 again.
- Assert reset for 1 cycle during CAPTURE with p1_score = 2 → all outputs at reset values next cycle. A start pulse during SHOW is ignored.
